// File: rtl/qos_out_pkt_tx_if.sv
// qos_out_pkt_tx_if
// Bundles the packet-buffer read side and the downstream word stream of the
// QoS egress transmitter.
//   master : transmitter side (drives rd_en, pkt_done and the output stream)
//   slave  : buffer / downstream side
// Signals:
//   pkt_avail, pkt_len  head-of-queue packet presence and word count
//   rd_en, rd_data      buffer read strobe, data one cycle after rd_en
//   pkt_done            retire the head length entry
//   tx_ready            downstream accepts the current word
//   pkt_valid, pkt_begin, pkt_end, pkt_out  framed output word stream
//   busy                transmitter not idle
interface qos_out_pkt_tx_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) ();
  logic              pkt_avail;
  logic [LEN_W-1:0]  pkt_len;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              pkt_done;
  logic              tx_ready;
  logic              pkt_valid;
  logic              pkt_begin;
  logic              pkt_end;
  logic [DATA_W-1:0] pkt_out;
  logic              busy;

  modport master (
    input  pkt_avail, pkt_len, rd_data, tx_ready,
    output rd_en, pkt_done, pkt_valid, pkt_begin, pkt_end, pkt_out, busy
  );

  modport slave (
    output pkt_avail, pkt_len, rd_data, tx_ready,
    input  rd_en, pkt_done, pkt_valid, pkt_begin, pkt_end, pkt_out, busy
  );
endinterface

// File: rtl/qos_out_pkt_tx.sv
// qos_out_pkt_tx
// Egress packet transmitter: drains one complete packet at a time from a
// word-addressed packet buffer and re-frames it onto a valid/ready word
// stream with begin/end markers.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    qos_out_pkt_tx_if.master (buffer read port + output stream)
// Optional feature: define QOS_TX_IFG_EN to insert IFG_CYCLES idle cycles
// (GAP state) after every pkt_done. Without it DONE returns straight to IDLE.
module qos_out_pkt_tx #(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int IFG_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  qos_out_pkt_tx_if.master   bus
);

  if (IFG_CYCLES < 1 || IFG_CYCLES > 255) begin : g_bad_ifg
    $error("IFG_CYCLES must be in 1..255");
  end

`ifdef QOS_TX_IFG_EN
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE, S_GAP} state_t;
  logic [7:0] gap_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;
`endif

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  rd_left;
  logic [LEN_W-1:0]  tx_left;
  logic [LEN_W-1:0]  len_lat;
  logic              rd_en_int;
  logic              pop;
  logic [2:0]        fill;

  // Read request stage: vld_p1 marks that rd_data carries a word this cycle.
  logic              vld_p1;

  // Holding stage: head drives pkt_out, skid absorbs one word of backpressure.
  logic              head_vld_p2;
  logic [DATA_W-1:0] head_data_p2;
  logic              skid_vld_p2;
  logic [DATA_W-1:0] skid_data_p2;

  assign pop  = head_vld_p2 & bus.tx_ready;
  // Words held plus words in flight after this cycle's pop; reads stop at 2
  // so the two-entry holding buffer can never overflow.
  assign fill = {2'b0, head_vld_p2} + {2'b0, skid_vld_p2} + {2'b0, vld_p1} - {2'b0, pop};

  always_comb begin
    state_nxt = state;
    rd_en_int = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.pkt_avail) begin
          if (bus.pkt_len != '0) begin
            rd_en_int = 1'b1;
            state_nxt = S_SEND;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_SEND: begin
        rd_en_int = (rd_left != '0) && (fill < 3'd2);
        if (pop && (tx_left == LEN_W'(1))) state_nxt = S_DONE;
      end
      S_DONE: begin
`ifdef QOS_TX_IFG_EN
        state_nxt = S_GAP;
`else
        state_nxt = S_IDLE;
`endif
      end
`ifdef QOS_TX_IFG_EN
      S_GAP: begin
        if (gap_cnt == 8'd0) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rd_left <= '0;
      tx_left <= '0;
      len_lat <= '0;
      vld_p1  <= 1'b0;
`ifdef QOS_TX_IFG_EN
      gap_cnt <= 8'd0;
`endif
    end else begin
      state  <= state_nxt;
      vld_p1 <= rd_en_int;
      if (state == S_IDLE) begin
        if (bus.pkt_avail && (bus.pkt_len != '0)) begin
          rd_left <= bus.pkt_len - 1'b1;
          tx_left <= bus.pkt_len;
          len_lat <= bus.pkt_len;
        end
      end else if (state == S_SEND) begin
        if (rd_en_int) rd_left <= rd_left - 1'b1;
        if (pop)       tx_left <= tx_left - 1'b1;
      end
`ifdef QOS_TX_IFG_EN
      if (state == S_DONE)     gap_cnt <= 8'(IFG_CYCLES - 1);
      else if (state == S_GAP) gap_cnt <= gap_cnt - 8'd1;
`endif
    end
  end

  // Holding buffer control and head word. The head is cleared by reset so
  // pkt_out reads 0 while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_vld_p2  <= 1'b0;
      head_data_p2 <= '0;
      skid_vld_p2  <= 1'b0;
    end else begin
      if (pop) begin
        if (skid_vld_p2) begin
          head_data_p2 <= skid_data_p2;
          skid_vld_p2  <= vld_p1;
        end else begin
          head_data_p2 <= bus.rd_data;
          head_vld_p2  <= vld_p1;
        end
      end else if (!head_vld_p2) begin
        head_data_p2 <= bus.rd_data;
        head_vld_p2  <= vld_p1;
      end else if (vld_p1) begin
        skid_vld_p2 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1 && head_vld_p2 && (!pop || skid_vld_p2)) skid_data_p2 <= bus.rd_data;
  end

  // rd_en is decoded from the IDLE state and pkt_avail, so it is also gated
  // by rst_n to keep the buffer quiet while reset is held.
  assign bus.rd_en     = rd_en_int & rst_n;
  assign bus.pkt_valid = head_vld_p2;
  assign bus.pkt_out   = head_data_p2;
  assign bus.pkt_begin = head_vld_p2 && (tx_left == len_lat);
  assign bus.pkt_end   = head_vld_p2 && (tx_left == LEN_W'(1));
  assign bus.pkt_done  = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_qos_out_pkt_tx.sv
module tb_qos_out_pkt_tx;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef QOS_TX_IFG_EN
  localparam int G = 2;
`else
  localparam int G = 0;
`endif

  qos_out_pkt_tx_if #(.DATA_W(32), .LEN_W(8)) bus ();

  qos_out_pkt_tx #(.DATA_W(32), .LEN_W(8), .IFG_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mem[$];
  logic [31:0] exp_data[$];
  logic [5:0]  ev[$];
  int rd_ptr;
  int pops;
  int done_cnt = 0;
  int d0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {rd_en, pkt_valid, pkt_begin, pkt_end, pkt_done, busy}
  function automatic logic [5:0] flags();
    return {bus.rd_en, bus.pkt_valid, bus.pkt_begin, bus.pkt_end, bus.pkt_done, bus.busy};
  endfunction

  // Ends one cycle: samples handshakes before the edge, then plays the
  // buffer (rd_data one cycle after rd_en) just after the edge.
  task automatic tick();
    logic re, pp, dn;
    re = bus.rd_en;
    pp = bus.pkt_valid & bus.tx_ready;
    dn = bus.pkt_done;
    @(posedge clk);
    #1;
    if (re) begin
      bus.rd_data = (rd_ptr < mem.size()) ? mem[rd_ptr] : 32'hBAD0_BAD0;
      rd_ptr++;
    end
    if (pp) pops++;
    if (dn) done_cnt++;
  endtask

  task automatic start(input logic [7:0] len);
    bus.pkt_len = len;
    rd_ptr = 0;
    pops = 0;
    d0 = done_cnt;
  endtask

  task automatic run(input string name, input int n, input int avail_off,
                     input int st_lo, input int st_hi);
    for (int c = 0; c < n; c++) begin
      bus.pkt_avail = (c < avail_off);
      bus.tx_ready  = !(c >= st_lo && c <= st_hi);
      #1;
      chk($sformatf("%s_flags_c%0d", name, c), {26'b0, flags()}, {26'b0, ev[c]});
      if (bus.pkt_valid)
        chk($sformatf("%s_data_c%0d", name, c), bus.pkt_out,
            (pops < exp_data.size()) ? exp_data[pops] : 32'hFFFF_FFFF);
      tick();
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.pkt_avail = 1'b1;
    bus.pkt_len   = 8'd5;
    bus.rd_data   = 32'd0;
    bus.tx_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", {26'b0, flags()}, 32'd0);
    chk("reset_out", bus.pkt_out, 32'd0);
    bus.pkt_avail = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single 5-word packet, tx_ready held high
    mem = '{32'd100, 32'd200, 32'd50, 32'd25, 32'd500};
    exp_data = mem;
    ev = '{6'b100000, 6'b100001, 6'b111001, 6'b110001, 6'b110001,
           6'b010001, 6'b010101, 6'b000011, 6'b000000};
    start(8'd5);
    run("single", 9, 1, -1, -1);
    chk("single_pops", 32'(pops), 32'd5);
    chk("single_done", 32'(done_cnt - d0), 32'd1);

    // 7-word packet with a 3-cycle stall on cycles 3-5
    mem = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17};
    exp_data = mem;
    ev = '{6'b100000, 6'b100001, 6'b111001, 6'b010001, 6'b010001, 6'b010001,
           6'b110001, 6'b110001, 6'b110001, 6'b110001, 6'b010001, 6'b010101,
           6'b000011, 6'b000000};
    start(8'd7);
    run("bp", 14, 1, 3, 5);
    chk("bp_pops", 32'(pops), 32'd7);
    chk("bp_reads", 32'(rd_ptr), 32'd7);
    chk("bp_done", 32'(done_cnt - d0), 32'd1);

    // 1-word packet: begin and end on the same word
    mem = '{32'hDEAD_BEEF};
    exp_data = mem;
    ev = '{6'b100000, 6'b000001, 6'b011101, 6'b000011, 6'b000000};
    start(8'd1);
    run("len1", 5, 1, -1, -1);
    chk("len1_pops", 32'(pops), 32'd1);
    chk("len1_done", 32'(done_cnt - d0), 32'd1);

    // Zero-length packet: straight to DONE, no reads, no words
    mem = {};
    exp_data = {};
    ev = '{6'b000000, 6'b000011, 6'b000000};
    start(8'd0);
    run("len0", 3, 1, -1, -1);
    chk("len0_reads", 32'(rd_ptr), 32'd0);
    chk("len0_pops", 32'(pops), 32'd0);
    chk("len0_done", 32'(done_cnt - d0), 32'd1);

    // Two back-to-back 4-word packets with pkt_avail held high
    mem = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    exp_data = mem;
    ev = '{6'b100000, 6'b100001, 6'b111001, 6'b110001, 6'b010001, 6'b010101, 6'b000011};
    for (int i = 0; i < G; i++) ev.push_back(6'b000001);
    ev.push_back(6'b100000); ev.push_back(6'b100001); ev.push_back(6'b111001);
    ev.push_back(6'b110001); ev.push_back(6'b010001); ev.push_back(6'b010101);
    ev.push_back(6'b000011); ev.push_back(6'b000000);
    start(8'd4);
    run("b2b", 15 + G, 8 + G, -1, -1);
    chk("b2b_pops", 32'(pops), 32'd8);
    chk("b2b_done", 32'(done_cnt - d0), 32'd2);

    // Reset while word 3 of a 7-word packet is on the output
    mem = '{32'd21, 32'd22, 32'd23, 32'd24, 32'd25, 32'd26, 32'd27};
    exp_data = mem;
    ev = '{6'b100000, 6'b100001, 6'b111001, 6'b110001, 6'b110001};
    start(8'd7);
    run("rst", 4, 99, -1, -1);
    #1;
    chk("rst_word3", bus.pkt_out, 32'd23);
    rst_n = 1'b0;
    #1;
    chk("rst_flags", {26'b0, flags()}, 32'd0);
    chk("rst_out", bus.pkt_out, 32'd0);
    tick();
    tick();
    bus.pkt_avail = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);

    mem = '{32'd31, 32'd32, 32'd33, 32'd34, 32'd35};
    exp_data = mem;
    ev = '{6'b100000, 6'b100001, 6'b111001, 6'b110001, 6'b110001,
           6'b010001, 6'b010101, 6'b000011, 6'b000000};
    start(8'd5);
    run("post", 9, 1, -1, -1);
    chk("post_pops", 32'(pops), 32'd5);
    chk("post_done", 32'(done_cnt - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/qos_out_pkt_tx.md
# qos_out_pkt_tx

Egress packet transmitter for the QoS queue path. It drains one complete packet at a time from a word-addressed packet buffer that exposes a read port and a head-of-queue length. It re-frames each packet onto the downstream `pkt_begin`/`pkt_end`/`pkt_out` word stream with valid/ready flow control. It is the read side of the temporary packet FIFOs: the FIFOs accept framed words, and this block emits them.

## Interface
- `DATA_W`, 32, word width of buffer data and `pkt_out`
- `LEN_W`, 8, width of the packet length in words
- `IFG_CYCLES`, 2, idle cycles between packets; used only when `QOS_TX_IFG_EN` is defined; legal range 1..255
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pkt_avail`  in  1  buffer holds at least one complete packet; `pkt_len` is valid while high
- `pkt_len`  in  LEN_W  word count of the head packet
- `rd_en`  out  1  read strobe to buffer; one word per asserted cycle
- `rd_data`  in  DATA_W  buffer data, valid exactly one cycle after `rd_en`
- `pkt_done`  out  1  one-cycle pulse telling the buffer to retire the head length entry
- `tx_ready`  in  1  downstream accepts the current word this cycle
- `pkt_valid`  out  1  `pkt_out` holds a valid word
- `pkt_begin`  out  1  current word is the first of its packet
- `pkt_end`  out  1  current word is the last of its packet
- `pkt_out`  out  DATA_W  output word
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SEND, DONE, GAP (GAP exists only with `QOS_TX_IFG_EN`).
- **IDLE:**
  - If `pkt_avail` is high and `pkt_len` is not 0: assert `rd_en` this cycle, load `rd_left = pkt_len-1` and `tx_left = pkt_len`, then go to SEND.
  - If `pkt_avail` is high and `pkt_len` is 0: go to DONE with no reads and no output words.
- **SEND, reads:**
  - `rd_en` = (`rd_left` != 0) AND (`occ` + `inflight` − `pop` < 2).
  - `occ` is the occupancy of a 2-entry output holding buffer.
  - `inflight` is the registered `rd_en` from the previous cycle.
  - `pop` is `pkt_valid & tx_ready`.
  - Every `rd_en` decrements `rd_left`.
- **SEND, data path:**
  - The holding buffer is a head register driving `pkt_out` plus one skid entry.
  - Returning `rd_data` is written into the head if it is empty or being popped, otherwise into the skid entry.
  - The skid entry moves to the head on a pop.
  - No word is ever dropped or duplicated.
- **SEND, framing:**
  - `pkt_begin` = `pkt_valid` AND (`tx_left` == `pkt_len_latched`).
  - `pkt_end` = `pkt_valid` AND (`tx_left` == 1).
  - A 1-word packet has `pkt_begin` and `pkt_end` both high on the same word.
  - Each pop decrements `tx_left`. A pop with `pkt_end` goes to DONE.
- **DONE:** assert `pkt_done` for one cycle.
  - Without `QOS_TX_IFG_EN`: go to IDLE.
  - With `QOS_TX_IFG_EN`: go to GAP.
- **GAP:** count `IFG_CYCLES` cycles, then go to IDLE. `pkt_avail` is ignored during GAP.
- `pkt_len` is sampled only in IDLE. Changes to it during a packet have no effect.
- Output words do not depend on `tx_ready` except through flow control. `pkt_valid`, once high, stays high with stable `pkt_out` until popped.

## Timing
- **Reset:** while `rst_n` is low, all outputs are 0, the state is IDLE, the holding buffer is empty, and the counters are 0.
- **Reset mid-packet:**
  - Takes effect immediately.
  - The partial packet is abandoned and no `pkt_done` is issued.
  - The buffer owner is responsible for its own reset.
- **Latency:** with `pkt_avail` rising in cycle 0 (IDLE), `rd_en` is high in cycle 0 and the first word appears with `pkt_valid`/`pkt_begin` in cycle 2.
- **Throughput:** with `tx_ready` held high, one word per cycle. `pkt_end` appears in cycle N+1 for an N-word packet, and `pkt_done` in cycle N+2.
- **Back-to-back packets:**
  - Without IFG: the next `rd_en` is at the earliest in the cycle after `pkt_done`, which gives 3 idle output cycles between packets.
  - With IFG: `IFG_CYCLES` are added to that gap.
- **Backpressure:** with `tx_ready` deasserted, at most 2 words are buffered and `rd_en` stops within 1 cycle.

## Configuration
- `QOS_TX_IFG_EN`
  - **Defined:** the GAP state inserts `IFG_CYCLES` idle cycles after every `pkt_done`. `busy` stays high during GAP.
  - **Undefined:** DONE returns directly to IDLE. There is no GAP state, no gap counter, and `IFG_CYCLES` is unused.

## Test plan
- **Single packet:** 5-word packet 100, 200, 50, 25, 500 with `tx_ready`=1 → `pkt_begin` with 100 in cycle 2, `pkt_end` with 500 in cycle 6, `pkt_done` in cycle 7, `busy` low in cycle 8.
- **Backpressure:** 7-word packet 11..17 with `tx_ready` low on cycles 3-5 → the stream holds 12 stable over the stall, exactly 7 pops occur, no duplicated or missing word, and never more than 2 `rd_en` outstanding beyond pops.
- **Length 1:**
  - `pkt_len`=1 with data 0xDEADBEEF → a single word with `pkt_begin` and `pkt_end` high together, then `pkt_done`.
  - `pkt_len`=0 → `pkt_done` 1 cycle after IDLE, no `rd_en`, no `pkt_valid`.
- **Back-to-back:** two 4-word packets with `pkt_avail` held high → 3 idle output cycles between them without `QOS_TX_IFG_EN`; 3+`IFG_CYCLES` with it defined and `IFG_CYCLES`=2.
- **Reset mid-packet:** assert `rst_n`=0 during word 3 of a 7-word packet → all outputs 0 in the same cycle and no `pkt_done`. After release, a new 5-word packet transmits correctly.
